// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encoding and the status-flag bundle.
package alu_pkg;

    typedef enum logic {
        ALU_OP_ADD = 1'b0,
        ALU_OP_SUB = 1'b1
    } alu_op_e;

    // Status flags; the same layout is latched by the ALU status register.
    typedef struct packed {
        logic c_out;
        logic ovf;
        logic zero;
    } alu_flags_t;

endpackage

// File: rtl/pipe_adder_stage.sv
// One pipeline slice of pipe_adder: resolves slice IDX of the running word,
// forwards the rest unchanged, and owns its valid bit and advance condition.
module pipe_adder_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SW     = 8,
    parameter int unsigned IDX    = 0,
    parameter bit          IS_MSB = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_acc,
    input  logic [WIDTH-1:0] in_bb,
    input  logic             in_carry,
    input  logic             next_adv,
    output logic             adv,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_acc,
    output logic [WIDTH-1:0] out_bb,
    output logic             out_carry,
    output logic             out_cmsb,
    output logic             out_zero
);

    // in_acc holds finished result slices below IDX and untouched operand A
    // slices from IDX upward, so one register carries both kinds of data.
    logic [SW-1:0]    sa;
    logic [SW-1:0]    sb;
    logic [SW-1:0]    slice_sum;
    logic             cmsb;
    logic [1:0]       hi;
    logic [WIDTH-1:0] next_acc;

    assign sa = in_acc[IDX*SW +: SW];
    assign sb = in_bb[IDX*SW +: SW];

    // Slice add is split below/at the top bit so the carry into the top bit is visible.
    generate
        if (SW > 1) begin : g_split
            logic [SW-1:0] lo;
            assign lo        = {1'b0, sa[SW-2:0]} + {1'b0, sb[SW-2:0]} + {{(SW-1){1'b0}}, in_carry};
            assign cmsb      = lo[SW-1];
            assign slice_sum = {hi[0], lo[SW-2:0]};
        end else begin : g_single
            assign cmsb      = in_carry;
            assign slice_sum = hi[0];
        end
    endgenerate

    assign hi = {1'b0, sa[SW-1]} + {1'b0, sb[SW-1]} + {1'b0, cmsb};

    // Merge the freshly computed slice into the travelling word.
    always_comb begin
        next_acc                 = in_acc;
        next_acc[IDX*SW +: SW]   = slice_sum;
    end

    // An empty stage always takes new data, so bubbles collapse under stall.
    assign adv = !out_valid || next_adv;

    // Stage register: loads only on advance; data is held when nothing valid arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_bb    <= '0;
            out_carry <= 1'b0;
        end else if (adv) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_acc   <= next_acc;
                out_bb    <= in_bb;
                out_carry <= hi[1];
            end
        end
    end

    generate
        if (IS_MSB) begin : g_msb
            // Final stage also captures carry-into-MSB and the zero flag of the full sum.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    out_cmsb <= 1'b0;
                    out_zero <= 1'b0;
                end else if (adv && in_valid) begin
                    out_cmsb <= cmsb;
                    out_zero <= (next_acc == '0);
                end
            end
        end else begin : g_mid
            assign out_cmsb = 1'b0;
            assign out_zero = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit: WIDTH bits split into STAGES slices, one slice
// resolved per stage, carry registered between stages, valid/ready both sides.
module pipe_adder
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned SW = WIDTH / STAGES;

    // Index k is the input side of stage k; index STAGES is the output register.
    logic             valid_p [STAGES+1];
    logic [WIDTH-1:0] acc_p   [STAGES+1];
    logic [WIDTH-1:0] bb_p    [STAGES+1];
    logic             carry_p [STAGES+1];
    logic             adv_p   [STAGES+1];
    logic             cmsb_s  [STAGES];
    logic             zero_s  [STAGES];

    alu_op_e    op;
    alu_flags_t flags;

    assign op         = alu_op_e'(sub);
    assign valid_p[0] = in_valid;
    assign acc_p[0]   = a;
    assign bb_p[0]    = (op == ALU_OP_SUB) ? ~b : b;
    assign carry_p[0] = (op == ALU_OP_SUB) ? 1'b1 : c_in;

    // Output side frees up when empty or when the consumer takes the result.
    assign adv_p[STAGES] = !valid_p[STAGES] || out_ready;
    assign in_ready      = adv_p[0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            pipe_adder_stage #(
                .WIDTH  (WIDTH),
                .SW     (SW),
                .IDX    (k),
                .IS_MSB (k == STAGES - 1)
            ) u_stage (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (valid_p[k]),
                .in_acc    (acc_p[k]),
                .in_bb     (bb_p[k]),
                .in_carry  (carry_p[k]),
                .next_adv  (adv_p[k+1]),
                .adv       (adv_p[k]),
                .out_valid (valid_p[k+1]),
                .out_acc   (acc_p[k+1]),
                .out_bb    (bb_p[k+1]),
                .out_carry (carry_p[k+1]),
                .out_cmsb  (cmsb_s[k]),
                .out_zero  (zero_s[k])
            );
        end
    endgenerate

    assign flags = '{
        c_out: carry_p[STAGES],
        ovf:   cmsb_s[STAGES-1] ^ carry_p[STAGES],
        zero:  zero_s[STAGES-1]
    };

    assign out_valid = valid_p[STAGES];
    assign sum       = acc_p[STAGES];
    assign c_out     = flags.c_out;
    assign ovf       = flags.ovf;
    assign zero      = flags.zero;

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit; successor to the single-bit full adder used in the CPU datapath.
- Splits a WIDTH-bit operation into STAGES equal slices. One slice is resolved per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides lets the ALU and the multi-cycle execute path stall it.
- Sustains one operation per cycle when not stalled.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); slice width SW = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands presented.
- in_ready  output  1  unit accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sub  input  1  0 = add, 1 = subtract (A - B).
- c_in  input  1  carry-in, used only when sub=0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result.
- c_out  output  1  carry-out of MSB. For sub it is the inverted-borrow convention: 1 means no borrow.
- ovf  output  1  signed two's-complement overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (async assert, sync release): all stage valid bits cleared.
  - out_valid=0, sum=0, c_out=0, ovf=0, zero=0.
  - in_ready=1 from the first cycle after release.
  - Reset mid-operation discards all in-flight operations; no partial result is ever emitted.
- Operand conditioning at acceptance:
  - bb = sub ? ~b : b.
  - cin = sub ? 1 : c_in.
  - Accept happens when in_valid && in_ready.
- Stage k (0..STAGES-1):
  - Computes slice k: a[k*SW +: SW] + bb[k*SW +: SW] + carry_k. carry_0 is cin; carry_k for k>0 is the registered carry from stage k-1.
  - Registers the SW-bit partial sum and the carry.
  - Slices not yet computed travel unchanged in stage registers.
  - Already-computed result slices also travel forward.
- The MSB slice additionally registers the carry into the MSB, so ovf = carry_into_msb XOR c_out.
- zero is computed in the final stage from the complete sum.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready stays 1.
  - STAGES=1 gives a single registered adder.
- Handshake:
  - Stage k advances when it is empty, or when stage k+1 advances. The last stage advances when !out_valid || out_ready.
  - in_ready = stage-0 advance condition, combinational from out_ready through the chain; no skid buffer.
  - Each stage holds its contents and valid bit while stalled.
  - Bubbles collapse: an empty stage accepts even if downstream is stalled.
- Output contract:
  - sum, c_out, ovf and zero are stable while out_valid=1 && out_ready=0.
  - They change only on a handshake.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.
- Wrap-around: arithmetic is modulo 2^WIDTH; c_out carries the lost bit.
- Width rules:
  - Slice adders are SW+1 bits wide.
  - The MSB slice is split internally (SW-1 bits, then 1 bit) to expose carry_into_msb.
  - SW=1 is legal: carry_into_msb is the slice carry-in.

Decomposition:
- Shared package alu_pkg:
  - ALU_OP_ADD=1'b0, ALU_OP_SUB=1'b1.
  - A flags struct {c_out, ovf, zero}, reused by the ALU status register.
- Sub-module pipe_adder_stage (parameters SW, IS_MSB).
  - Contains one slice adder, pass-through registers and the local valid/advance logic.
  - Instantiated STAGES times by generate.

Test Plan (WIDTH=32, STAGES=4 unless noted):
- Basic add, long carry chain:
  - Stimulus: a=0xFFFF_FFFF, b=0x0000_0001, sub=0, c_in=0, out_ready=1.
  - Required: out_valid exactly 4 cycles after accept; sum=0, c_out=1, ovf=0, zero=1.
- Subtract and signed overflow:
  - Stimulus: a=0x8000_0000, b=1, sub=1.
  - Required: sum=0x7FFF_FFFF, c_out=1, ovf=1.
  - Stimulus: a=3, b=5, sub=1.
  - Required: sum=0xFFFF_FFFE, c_out=0, ovf=0.
- Throughput:
  - Stimulus: 8 back-to-back ops with a=i, b=i, c_in=1, out_ready=1.
  - Required: in_ready stays 1; results 2i+1 in order on 8 consecutive cycles.
- Back-pressure:
  - Stimulus: drop out_ready for 6 cycles mid-stream.
  - Required: in_ready falls once 4 ops are held.
  - Required: outputs are stable while stalled.
  - Required: no op is lost or duplicated, and order is preserved after out_ready returns.
- Reset mid-flight:
  - Stimulus: assert rst_n=0 with 3 ops in flight, asynchronously between edges.
  - Required: out_valid=0 immediately, all outputs 0.
  - Required: after release, the first new op returns the correct result after 4 cycles.
- Parameter sweep:
  - Stimulus: STAGES=1, WIDTH=8 and STAGES=8, WIDTH=8.
  - Required: random 1000 ops match a reference model of a ± b with c_out/ovf/zero.
  - Required: latency equals STAGES.
